// File: rtl/lsu_ahb_swc_if.sv
// AHB-Lite single-transfer bus bundle between the LSU (master) and the memory fabric (slave).
interface lsu_ahb_swc_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/lsu_ahb_swc.sv
// Load/store unit: one single AHB-Lite transfer per exu request, load data aligned/extended and
// written back to the register file; lsu_stall holds the pipeline until the transfer retires.
module lsu_ahb_swc #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic        exu_load_en,
    input  logic [4:0]  exu_load_rd,
    input  logic [31:0] exu_load_base_addr,
    input  logic [31:0] exu_load_offset,
    input  logic        exu_load_sext,
    input  logic [1:0]  exu_load_size,
    input  logic        exu_store_en,
    input  logic [31:0] exu_store_addr,
    input  logic [31:0] exu_store_data,
    input  logic [1:0]  exu_store_size,
    lsu_ahb_swc_if.master ahb,
    output logic [4:0]  lsu_reg_waddr,
    output logic [31:0] lsu_reg_wdata,
    output logic        lsu_reg_wen,
    output logic        lsu_stall,
    output logic        lsu_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic        WDOG_EN       = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WDOG_LAST     = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic [4:0]  rd_q, rd_d;
    logic        sext_q, sext_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        coll_q, coll_d;
    logic [15:0] wdog_q, wdog_d;

    logic [31:0] load_addr;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_any;
    logic        req_misalign;
    logic        wdog_hit;

    // Load wins over a simultaneous store; the dropped store is reported through lsu_err.
    assign load_addr = exu_load_base_addr + exu_load_offset;
    assign req_any   = exu_load_en | exu_store_en;
    assign req_addr  = exu_load_en ? load_addr : exu_store_addr;
    assign req_size  = exu_load_en ? exu_load_size : exu_store_size;

    always_comb begin
        req_misalign = 1'b0;
        case (req_size)
            2'd0:    req_misalign = 1'b0;
            2'd1:    req_misalign = req_addr[0];
            2'd2:    req_misalign = (req_addr[1:0] != 2'b00);
            default: req_misalign = 1'b1;
        endcase
    end

    assign wdog_hit = WDOG_EN && !ahb.hready && (wdog_q == WDOG_LAST);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        rd_d    = rd_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        coll_d  = coll_q;
        wdog_d  = 16'd0;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    write_d = ~exu_load_en;
                    rd_d    = exu_load_rd;
                    sext_d  = exu_load_sext;
                    wdata_d = exu_store_data;
                    coll_d  = exu_load_en & exu_store_en;
                    fault_d = req_misalign;
                    state_d = req_misalign ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ahb.hready) begin
                    state_d = ST_DATA;
                end else if (wdog_hit) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            ST_DATA: begin
                // Leave on the first cycle of an error response; its second cycle lands in DONE.
                if (ahb.hresp) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else if (ahb.hready) begin
                    rdata_d = ahb.hrdata;
                    state_d = ST_DONE;
                end else if (wdog_hit) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            default: begin
                fault_d = 1'b0;
                coll_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            rd_q    <= '0;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            coll_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            rd_q    <= rd_d;
            sext_q  <= sext_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            coll_q  <= coll_d;
            wdog_q  <= wdog_d;
        end
    end

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] store_lanes;

    assign load_byte = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    assign load_half = rdata_q[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext    = rdata_q;
        store_lanes = wdata_q;
        case (size_q)
            2'd0: begin
                load_ext    = {{24{sext_q & load_byte[7]}}, load_byte};
                store_lanes = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                load_ext    = {{16{sext_q & load_half[15]}}, load_half};
                store_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                load_ext    = rdata_q;
                store_lanes = wdata_q;
            end
        endcase
    end

    assign ahb.htrans = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb.haddr  = (state_q == ST_ADDR) ? addr_q : 32'd0;
    assign ahb.hwrite = (state_q == ST_ADDR) & write_q;
    assign ahb.hsize  = (state_q == ST_ADDR) ? {1'b0, size_q} : 3'd0;
    assign ahb.hwdata = ((state_q == ST_DATA) & write_q) ? store_lanes : 32'd0;

    assign lsu_reg_wen   = (state_q == ST_DONE) & ~fault_q & ~write_q & (rd_q != 5'd0);
    assign lsu_reg_waddr = lsu_reg_wen ? rd_q : 5'd0;
    assign lsu_reg_wdata = lsu_reg_wen ? load_ext : 32'd0;
    assign lsu_err       = (state_q == ST_DONE) & (fault_q | coll_q);
    assign lsu_stall     = ((state_q == ST_IDLE) & req_any)
                         | (state_q == ST_ADDR) | (state_q == ST_DATA);

endmodule

// File: tb/tb_lsu_ahb_swc.sv
// Directed scoreboard bench for lsu_ahb_swc: expectations are queued per request and a negedge
// monitor checks address phases, write data and writeback/error pulses as the DUT produces them.
module tb_lsu_ahb_swc;

    logic        hclk = 1'b0;
    logic        hrstn = 1'b0;
    logic        exu_load_en = 1'b0;
    logic [4:0]  exu_load_rd = '0;
    logic [31:0] exu_load_base_addr = '0;
    logic [31:0] exu_load_offset = '0;
    logic        exu_load_sext = 1'b0;
    logic [1:0]  exu_load_size = '0;
    logic        exu_store_en = 1'b0;
    logic [31:0] exu_store_addr = '0;
    logic [31:0] exu_store_data = '0;
    logic [1:0]  exu_store_size = '0;
    logic [4:0]  lsu_reg_waddr;
    logic [31:0] lsu_reg_wdata;
    logic        lsu_reg_wen;
    logic        lsu_stall;
    logic        lsu_err;

    lsu_ahb_swc_if bus();

    lsu_ahb_swc #(.TIMEOUT_CYCLES(4)) dut (
        .hclk               (hclk),
        .hrstn              (hrstn),
        .exu_load_en        (exu_load_en),
        .exu_load_rd        (exu_load_rd),
        .exu_load_base_addr (exu_load_base_addr),
        .exu_load_offset    (exu_load_offset),
        .exu_load_sext      (exu_load_sext),
        .exu_load_size      (exu_load_size),
        .exu_store_en       (exu_store_en),
        .exu_store_addr     (exu_store_addr),
        .exu_store_data     (exu_store_data),
        .exu_store_size     (exu_store_size),
        .ahb                (bus),
        .lsu_reg_waddr      (lsu_reg_waddr),
        .lsu_reg_wdata      (lsu_reg_wdata),
        .lsu_reg_wen        (lsu_reg_wen),
        .lsu_stall          (lsu_stall),
        .lsu_err            (lsu_err)
    );

    always #5 hclk = ~hclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [35:0] exp_addr_q[$];   // {hwrite, hsize, haddr}
    logic [31:0] exp_wd_q[$];
    logic [37:0] exp_resp_q[$];   // {is_err, rd, data}

    logic [31:0] rdata_val = '0;
    int          wait_n = 0;
    bit          err_mode = 1'b0;
    bit          hold_low = 1'b0;
    bit          mon_dph = 1'b0;
    bit          mon_first = 1'b0;
    bit          mon_wr = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_addr(input logic [31:0] a, input logic wr, input logic [1:0] sz);
        exp_addr_q.push_back({wr, 1'b0, sz, a});
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
        exp_resp_q.push_back({1'b0, rd, d});
    endtask

    task automatic push_err();
        exp_resp_q.push_back({1'b1, 5'd0, 32'd0});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " haddr"},  bus.haddr, 0);
        chk({tag, " htrans"}, bus.htrans, 0);
        chk({tag, " hwrite"}, bus.hwrite, 0);
        chk({tag, " hsize"},  bus.hsize, 0);
        chk({tag, " hwdata"}, bus.hwdata, 0);
        chk({tag, " wen"},    lsu_reg_wen, 0);
        chk({tag, " waddr"},  lsu_reg_waddr, 0);
        chk({tag, " wdata"},  lsu_reg_wdata, 0);
        chk({tag, " stall"},  lsu_stall, 0);
        chk({tag, " err"},    lsu_err, 0);
    endtask

    task automatic do_req(input string nm, input logic ld, input logic st,
                          input logic [31:0] base, input logic [31:0] off,
                          input logic [1:0] lsz, input logic sx, input logic [4:0] rd,
                          input logic [31:0] saddr, input logic [31:0] sdata,
                          input logic [1:0] ssz, input int exp_stall);
        int n;
        @(negedge hclk); #1;
        exu_load_en = ld;        exu_store_en = st;
        exu_load_base_addr = base; exu_load_offset = off;
        exu_load_size = lsz;     exu_load_sext = sx; exu_load_rd = rd;
        exu_store_addr = saddr;  exu_store_data = sdata; exu_store_size = ssz;
        n = 0;
        forever begin
            @(negedge hclk); #1;
            if (!lsu_stall) break;
            n++;
            if (n > 100) begin
                n_cmp++; n_bad++;
                $display("FAIL %s: stall never released (limit 100 cycles)", nm);
                break;
            end
        end
        exu_load_en = 1'b0;
        exu_store_en = 1'b0;
        chk({nm, " stall cycles"}, n, exp_stall);
        $display("txn %s: stall cycles %0d (expected %0d)", nm, n, exp_stall);
        repeat (2) @(negedge hclk);
    endtask

    // Slave: responds just after each rising edge, from the data-phase flag the monitor keeps.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        bus.hrdata = '0;
        forever begin
            @(posedge hclk); #1;
            bus.hrdata = rdata_val;
            if (!hrstn) begin
                wcnt = 0; bus.hready = 1'b1; bus.hresp = 1'b0;
            end else if (mon_dph) begin
                if (err_mode) begin
                    if (wcnt == 0) begin bus.hready = 1'b0; bus.hresp = 1'b1; wcnt = 1; end
                    else begin bus.hready = 1'b1; bus.hresp = 1'b1; wcnt = 0; end
                end else if (wcnt < wait_n) begin
                    bus.hready = 1'b0; bus.hresp = 1'b0; wcnt++;
                end else begin
                    bus.hready = 1'b1; bus.hresp = 1'b0; wcnt = 0;
                end
            end else begin
                bus.hready = !hold_low; bus.hresp = 1'b0; wcnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an address phase, write data or a pulse.
    initial begin
        logic [37:0] r;
        logic [35:0] a;
        logic [31:0] w;
        forever begin
            @(negedge hclk);
            if (!hrstn) begin
                mon_dph = 1'b0; mon_first = 1'b0;
            end else begin
                if (lsu_err) begin
                    if (exp_resp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL err event: got unexpected lsu_err pulse, required none");
                    end else begin
                        r = exp_resp_q.pop_front();
                        chk("err event", lsu_err, r[37]);
                    end
                end
                if (lsu_reg_wen) begin
                    if (exp_resp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL wb event: got wen x%0d=%h, required none", lsu_reg_waddr, lsu_reg_wdata);
                    end else begin
                        r = exp_resp_q.pop_front();
                        chk("wb event", {lsu_reg_wen, lsu_reg_waddr, lsu_reg_wdata}, {~r[37], r[36:0]});
                    end
                end
                if (mon_dph && mon_first) begin
                    if (mon_wr) begin
                        if (exp_wd_q.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL hwdata: got %h with no store expected", bus.hwdata);
                        end else begin
                            w = exp_wd_q.pop_front();
                            chk("hwdata", bus.hwdata, w);
                        end
                    end
                    mon_first = 1'b0;
                end
                if (bus.htrans == 2'b10 && bus.hready) begin
                    if (exp_addr_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL addr phase: got NONSEQ to %h, required no transfer", bus.haddr);
                    end else begin
                        a = exp_addr_q.pop_front();
                        chk("addr phase", {bus.hwrite, bus.hsize, bus.haddr}, a);
                    end
                    mon_dph = 1'b1; mon_first = 1'b1; mon_wr = bus.hwrite;
                end else if (mon_dph && bus.hready) begin
                    mon_dph = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(negedge hclk);
        check_zero("reset");
        #1 hrstn = 1'b1;
        repeat (2) @(negedge hclk);

        rdata_val = 32'hDEADBEEF; push_addr(32'h1004, 1'b0, 2'd2); push_wb(5'd5, 32'hDEADBEEF);
        do_req("lw x5", 1, 0, 32'h1000, 32'h4, 2'd2, 0, 5'd5, 0, 0, 0, 2);

        rdata_val = 32'h80123456; push_addr(32'h2003, 1'b0, 2'd0); push_wb(5'd6, 32'hFFFFFF80);
        do_req("lb sext", 1, 0, 32'h2000, 32'h3, 2'd0, 1, 5'd6, 0, 0, 0, 2);

        push_addr(32'h2003, 1'b0, 2'd0); push_wb(5'd6, 32'h00000080);
        do_req("lbu", 1, 0, 32'h2000, 32'h3, 2'd0, 0, 5'd6, 0, 0, 0, 2);

        rdata_val = 32'h80017FFF; push_addr(32'h2002, 1'b0, 2'd1); push_wb(5'd8, 32'hFFFF8001);
        do_req("lh upper", 1, 0, 32'h2000, 32'h2, 2'd1, 1, 5'd8, 0, 0, 0, 2);

        rdata_val = 32'h1234F00F; push_addr(32'h2000, 1'b0, 2'd1); push_wb(5'd13, 32'hFFFFF00F);
        do_req("lh lower", 1, 0, 32'h2000, 32'h0, 2'd1, 1, 5'd13, 0, 0, 0, 2);

        rdata_val = 32'h12345678; push_addr(32'h2001, 1'b0, 2'd0); push_wb(5'd9, 32'h00000056);
        do_req("lb lane1", 1, 0, 32'h2000, 32'h1, 2'd0, 1, 5'd9, 0, 0, 0, 2);

        wait_n = 3; push_addr(32'h3002, 1'b1, 2'd1); exp_wd_q.push_back(32'hABCDABCD);
        do_req("sh wait3", 0, 1, 0, 0, 0, 0, 0, 32'h3002, 32'h1234ABCD, 2'd1, 5);
        wait_n = 0;

        push_addr(32'h3001, 1'b1, 2'd0); exp_wd_q.push_back(32'hA5A5A5A5);
        do_req("sb", 0, 1, 0, 0, 0, 0, 0, 32'h3001, 32'h000000A5, 2'd0, 2);

        push_addr(32'h3004, 1'b1, 2'd2); exp_wd_q.push_back(32'hCAFEF00D);
        do_req("sw", 0, 1, 0, 0, 0, 0, 0, 32'h3004, 32'hCAFEF00D, 2'd2, 2);

        push_err();
        do_req("lw misaligned", 1, 0, 32'h4000, 32'h2, 2'd2, 0, 5'd3, 0, 0, 0, 0);
        push_err();
        do_req("lh misaligned", 1, 0, 32'h5001, 32'h0, 2'd1, 0, 5'd3, 0, 0, 0, 0);
        push_err();
        do_req("load size3", 1, 0, 32'h5000, 32'h0, 2'd3, 0, 5'd3, 0, 0, 0, 0);
        push_err();
        do_req("sw misaligned", 0, 1, 0, 0, 0, 0, 0, 32'h3001, 32'h1, 2'd2, 0);
        push_err();
        do_req("store size3", 0, 1, 0, 0, 0, 0, 0, 32'h3000, 32'h1, 2'd3, 0);

        rdata_val = 32'h11223344; push_addr(32'h00000004, 1'b0, 2'd2); push_wb(5'd10, 32'h11223344);
        do_req("lw wrap", 1, 0, 32'hFFFFFFFC, 32'h8, 2'd2, 0, 5'd10, 0, 0, 0, 2);

        push_addr(32'h1000, 1'b0, 2'd2);
        do_req("lw x0", 1, 0, 32'h1000, 32'h0, 2'd2, 0, 5'd0, 0, 0, 0, 2);

        err_mode = 1'b1; push_addr(32'h1000, 1'b0, 2'd2); push_err();
        do_req("lw hresp", 1, 0, 32'h1000, 32'h0, 2'd2, 0, 5'd7, 0, 0, 0, 2);
        err_mode = 1'b0;

        rdata_val = 32'h00000055; push_addr(32'h1010, 1'b0, 2'd2); push_err(); push_wb(5'd11, 32'h55);
        do_req("load+store", 1, 1, 32'h1000, 32'h10, 2'd2, 0, 5'd11, 32'h3000, 32'h99, 2'd2, 2);

        hold_low = 1'b1; push_err();
        do_req("lw timeout", 1, 0, 32'h1008, 32'h0, 2'd2, 0, 5'd12, 0, 0, 0, 4);
        hold_low = 1'b0;

        // Reset while a store sits in its data phase.
        wait_n = 5; push_addr(32'h6000, 1'b1, 2'd2); exp_wd_q.push_back(32'h12345678);
        @(negedge hclk); #1;
        exu_store_en = 1'b1; exu_store_addr = 32'h6000;
        exu_store_data = 32'h12345678; exu_store_size = 2'd2;
        repeat (2) begin @(negedge hclk); #1; end
        chk("pre-reset stall", lsu_stall, 1);
        hrstn = 1'b0; exu_store_en = 1'b0;
        @(negedge hclk);
        check_zero("mid-data reset");
        $display("txn mid-data reset: outputs sampled under reset");
        #1 hrstn = 1'b1; wait_n = 0;
        repeat (4) @(negedge hclk);

        chk("resp queue drained", exp_resp_q.size(), 0);
        chk("addr queue drained", exp_addr_q.size(), 0);
        chk("wdata queue drained", exp_wd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
